glitcbus_master_v2: RTL and testbench

GLITCBUS_MASTER_V2 -- requirements
Module: glitcbus_master_v2

---
 rtl/glitcbus_pkg.sv | 20 ++
 rtl/glitcbus_master_v2.sv | 190 +++++++++++++++++++
 tb/tb_glitcbus_master_v2.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/glitcbus_pkg.sv
// Shared GLITCBUS definitions: transaction state encoding, beat counts and RDWR_B polarity.
// Used by both the master and the slave so the two ends agree on framing.
package glitcbus_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWdata = 3'd2,
        StTurn  = 3'd3,
        StRdata = 3'd4,
        StGap   = 3'd5
    } state_e;

    localparam int unsigned ADDR_BEATS = 2;
    localparam int unsigned DATA_BEATS = 4;

    localparam logic RDWR_B_READ  = 1'b1;
    localparam logic RDWR_B_WRITE = 1'b0;

endpackage

// File: rtl/glitcbus_master_v2.sv
// GLITCBUS master: turns a local register request into a byte-serial bus transaction.
// Every bus pin is a flop loaded from the next-state decode, so pins change only on clk_i.
module glitcbus_master_v2
    import glitcbus_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [15:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        GSEL_B,
    output logic        GRDWR_B,
    output logic [7:0]  gad_o,
    output logic        gad_oe_o,
    input  logic [7:0]  gad_i
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BEATS - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BEATS - 1);
    localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);

    state_e      r_state;
    logic [2:0]  r_beat;
    logic        r_wr;
    logic [15:0] r_adr;
    logic [31:0] r_wdat;
    logic [23:0] r_rshift;
    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_busy;
    logic        r_sel_b;
    logic        r_rdwr_b;
    logic [7:0]  r_gad;
    logic        r_gad_oe;

    state_e      w_state_d;
    logic [2:0]  w_beat_d;
    logic        w_latch;
    logic        w_wr;
    logic [15:0] w_adr;
    logic [31:0] w_wdat;
    logic        w_ack_d;
    logic        w_busy_d;
    logic        w_sel_b_d;
    logic        w_rdwr_b_d;
    logic [7:0]  w_gad_d;
    logic        w_gad_oe_d;

    always_comb begin
        w_state_d = r_state;
        w_beat_d  = r_beat;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_i) begin
                    w_latch   = 1'b1;
                    w_state_d = StAddr;
                    w_beat_d  = 3'd0;
                end
            end
            StAddr: begin
                if (r_beat == ADDR_LAST) begin
                    w_state_d = r_wr ? StWdata : StTurn;
                    w_beat_d  = 3'd0;
                end else begin
                    w_beat_d = r_beat + 3'd1;
                end
            end
            StWdata, StRdata: begin
                if (r_beat == DATA_LAST) begin
                    w_state_d = StGap;
                    w_beat_d  = 3'd0;
                end else begin
                    w_beat_d = r_beat + 3'd1;
                end
            end
            StTurn: begin
                if (r_beat == TURN_LAST) begin
                    w_state_d = StRdata;
                    w_beat_d  = 3'd0;
                end else begin
                    w_beat_d = r_beat + 3'd1;
                end
            end
            StGap: begin
                w_state_d = StIdle;
                w_beat_d  = 3'd0;
            end
            default: begin
                w_state_d = StIdle;
                w_beat_d  = 3'd0;
            end
        endcase
    end

    // First address beat is loaded on the accept edge, before the latches hold the request.
    assign w_wr   = w_latch ? wr_i  : r_wr;
    assign w_adr  = w_latch ? adr_i : r_adr;
    assign w_wdat = w_latch ? dat_i : r_wdat;

    always_comb begin
        w_sel_b_d  = 1'b1;
        w_rdwr_b_d = RDWR_B_READ;
        w_gad_d    = 8'h00;
        w_gad_oe_d = 1'b0;
        w_ack_d    = 1'b0;
        w_busy_d   = 1'b1;
        unique case (w_state_d)
            StIdle: w_busy_d = 1'b0;
            StAddr: begin
                w_sel_b_d  = 1'b0;
                w_rdwr_b_d = w_wr ? RDWR_B_WRITE : RDWR_B_READ;
                w_gad_oe_d = 1'b1;
                w_gad_d    = w_beat_d[0] ? w_adr[7:0] : w_adr[15:8];
            end
            StWdata: begin
                w_sel_b_d  = 1'b0;
                w_rdwr_b_d = RDWR_B_WRITE;
                w_gad_oe_d = 1'b1;
                unique case (w_beat_d[1:0])
                    2'd0:    w_gad_d = w_wdat[31:24];
                    2'd1:    w_gad_d = w_wdat[23:16];
                    2'd2:    w_gad_d = w_wdat[15:8];
                    default: w_gad_d = w_wdat[7:0];
                endcase
            end
            StTurn, StRdata: begin
                w_sel_b_d  = 1'b0;
                w_rdwr_b_d = RDWR_B_READ;
            end
            StGap:   w_ack_d  = 1'b1;
            default: w_busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= StIdle;
            r_beat   <= 3'd0;
            r_wr     <= 1'b0;
            r_adr    <= 16'h0000;
            r_wdat   <= 32'h0000_0000;
            r_rshift <= 24'h00_0000;
            r_dat    <= 32'h0000_0000;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_sel_b  <= 1'b1;
            r_rdwr_b <= RDWR_B_READ;
            r_gad    <= 8'h00;
            r_gad_oe <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_beat   <= w_beat_d;
            r_ack    <= w_ack_d;
            r_busy   <= w_busy_d;
            r_sel_b  <= w_sel_b_d;
            r_rdwr_b <= w_rdwr_b_d;
            r_gad    <= w_gad_d;
            r_gad_oe <= w_gad_oe_d;
            if (w_latch) begin
                r_wr   <= wr_i;
                r_adr  <= adr_i;
                r_wdat <= dat_i;
            end
            // Slave byte is sampled on the edge that ends each read-data beat.
            if (r_state == StRdata) begin
                if (r_beat == DATA_LAST) begin
                    r_dat <= {r_rshift, gad_i};
                end else begin
                    r_rshift <= {r_rshift[15:0], gad_i};
                end
            end
        end
    end

    assign dat_o    = r_dat;
    assign ack_o    = r_ack;
    assign busy_o   = r_busy;
    assign GSEL_B   = r_sel_b;
    assign GRDWR_B  = r_rdwr_b;
    assign gad_o    = r_gad;
    assign gad_oe_o = r_gad_oe;

endmodule

// File: tb/tb_glitcbus_master_v2.sv
// Randomized bench for glitcbus_master_v2: three builds (TURNAROUND 1, 2, 7) run side by side
// against a cycle-indexed transaction schedule model and a byte-serving slave model.
module tb_glitcbus_master_v2;

    localparam int NI = 3;
    localparam int TAS [NI] = '{1, 2, 7};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] adr = 16'h0;
    logic [31:0] dat = 32'h0;

    logic [31:0] dat_o_w  [NI];
    logic        ack_w    [NI];
    logic        busy_w   [NI];
    logic        sel_w    [NI];
    logic        rdwr_w   [NI];
    logic [7:0]  gad_o_w  [NI];
    logic        oe_w     [NI];
    logic [7:0]  gad_i_w  [NI];

    logic [31:0] exp_dat  [NI];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        glitcbus_master_v2 #(.TURNAROUND(TAS[g])) u_dut (
            .clk_i    (clk),
            .rst_n_i  (rst_n),
            .req_i    (req),
            .wr_i     (wr),
            .adr_i    (adr),
            .dat_i    (dat),
            .dat_o    (dat_o_w[g]),
            .ack_o    (ack_w[g]),
            .busy_o   (busy_w[g]),
            .GSEL_B   (sel_w[g]),
            .GRDWR_B  (rdwr_w[g]),
            .gad_o    (gad_o_w[g]),
            .gad_oe_o (oe_w[g]),
            .gad_i    (gad_i_w[g])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {GSEL_B, GRDWR_B, gad_oe_o, gad_o, ack_o, busy_o, dat_o}
    function automatic logic [44:0] observe(int i);
        return {sel_w[i], rdwr_w[i], oe_w[i], gad_o_w[i], ack_w[i], busy_w[i], dat_o_w[i]};
    endfunction

    function automatic logic [44:0] idle_bus(logic [31:0] d);
        return {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, d};
    endfunction

    // Expected pins in cycle k after the accept edge (k=1 is the first address beat).
    function automatic logic [44:0] exp_bus(int ta, int k, logic t_wr, logic [15:0] t_adr,
                                            logic [31:0] t_dat, logic [31:0] prev,
                                            logic [31:0] rdata);
        int gap;
        logic sel, rdwr, oe, ack, busy;
        logic [7:0] gad;
        logic [31:0] dout;
        gap = t_wr ? 7 : 7 + ta;
        sel = 1'b1; rdwr = 1'b1; oe = 1'b0; gad = 8'h00; ack = 1'b0; busy = 1'b0;
        dout = prev;
        if (k >= 1 && k < gap) begin
            sel  = 1'b0;
            busy = 1'b1;
            rdwr = ~t_wr;
            if (k <= 2) begin
                oe  = 1'b1;
                gad = (k == 1) ? t_adr[15:8] : t_adr[7:0];
            end else if (t_wr) begin
                oe  = 1'b1;
                gad = t_dat[8*(6-k) +: 8];
            end
        end else if (k == gap) begin
            ack  = 1'b1;
            busy = 1'b1;
            if (!t_wr) dout = rdata;
        end else if (k > gap) begin
            if (!t_wr) dout = rdata;
        end
        return {sel, rdwr, oe, gad, ack, busy, dout};
    endfunction

    function automatic logic [7:0] slave_byte(int ta, int k, logic t_wr, logic [31:0] rdata);
        int j;
        j = k - 3 - ta;
        if (!t_wr && j >= 0 && j <= 3) return rdata[8*(3-j) +: 8];
        return 8'($urandom);
    endfunction

    task automatic run_txn(input int id, input logic t_wr, input logic [15:0] t_adr,
                           input logic [31:0] t_dat, input logic [31:0] t_rdata,
                           input bit pre, input bit chain, input int abort_k);
        logic [31:0] prev [NI];
        int last;
        for (int i = 0; i < NI; i++) prev[i] = exp_dat[i];
        req = 1'b1; wr = t_wr; adr = t_adr; dat = t_dat;
        if (pre) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++)
                check_eq($sformatf("t%0d/i%0d/gap_idle", id, i), observe(i), idle_bus(prev[i]));
        end
        @(posedge clk); #1;
        last = chain ? 7 : 15;
        for (int k = 1; k <= last; k++) begin
            for (int i = 0; i < NI; i++) begin
                check_eq($sformatf("t%0d/i%0d/k%0d", id, i, k), observe(i),
                         exp_bus(TAS[i], k, t_wr, t_adr, t_dat, prev[i], t_rdata));
                gad_i_w[i] = slave_byte(TAS[i], k, t_wr, t_rdata);
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                req   = 1'b0;
                @(posedge clk); #1;
                for (int i = 0; i < NI; i++) begin
                    check_eq($sformatf("t%0d/i%0d/abort", id, i), observe(i), idle_bus(32'h0));
                    exp_dat[i] = 32'h0;
                end
                return;
            end
            if (k == last && chain) break;
            // Requests while busy must be ignored.
            if (k <= 6) begin
                req = 1'($urandom); wr = 1'($urandom); adr = 16'($urandom); dat = $urandom;
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < NI; i++) exp_dat[i] = t_wr ? prev[i] : t_rdata;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            gad_i_w[i] = 8'h00;
            exp_dat[i] = 32'h0;
        end
        rst_n = 1'b0;
        req   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            check_eq($sformatf("reset/i%0d", i), observe(i), idle_bus(32'h0));

        // First req seen with reset released is honoured.
        rst_n = 1'b1;
        run_txn(0, 1'b1, 16'h0042, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 0);
        run_txn(1, 1'b0, 16'h0010, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 0);

        // req held high: back-to-back writes.
        run_txn(2, 1'b1, 16'hA5C3, 32'h0102_0304, 32'h0, 1'b0, 1'b1, 0);
        run_txn(3, 1'b1, 16'h5A3C, 32'hF0E1_D2C3, 32'h0, 1'b1, 1'b0, 0);

        for (int t = 4; t < 34; t++)
            run_txn(t, 1'($urandom), 16'($urandom), $urandom, $urandom, 1'b0, 1'b0, 0);

        // Reset during the second read-data beat of the TURNAROUND=2 build.
        run_txn(40, 1'b0, 16'h0777, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 6);
        for (int c = 0; c < 2; c++) begin
            req = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++)
                check_eq($sformatf("in_reset/i%0d/c%0d", i, c), observe(i), idle_bus(32'h0));
        end
        rst_n = 1'b1;
        run_txn(41, 1'b0, 16'h0123, 32'h0, 32'h8765_4321, 1'b0, 1'b0, 0);
        run_txn(42, 1'b1, 16'hFFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
